sap1_control_sequencer: RTL and testbench
=========================================

Name: sap1_control_sequencer

Overview:
- Control unit for the SAP-1 datapath.
- Consumes the 4-bit opcode produced by the instruction register and steps a six-state one-hot ring counter (T1..T6).
- Drives the 12-bit control word for all datapath blocks, including the IR's own nLi/nEi strobes, plus a sticky HLT flag.
- Sits directly downstream of the IR and upstream of PC, MAR, RAM, A, B, ALU and output register.

Parameters:
- OPCODE_W, 4, opcode width (fixed by the instruction format).
- NUM_T, 6, number of T-states per instruction cycle (one-hot width).

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- CLR  input  1  synchronous, active-high reset.
- opcode  input  4  opcode from IR; must be stable from T4 through T6.
- tstate  output  6  one-hot current T-state; bit0=T1 .. bit5=T6.
- Cp  output  1  PC increment, active-high.
- Ep  output  1  PC output enable, active-high.
- nLm  output  1  MAR load, active-low.
- nCE  output  1  RAM output enable, active-low.
- nLi  output  1  IR load, active-low.
- nEi  output  1  IR address output enable, active-low.
- nLa  output  1  A load, active-low.
- Ea  output  1  A output enable, active-high.
- Su  output  1  ALU subtract select, active-high.
- Eu  output  1  ALU output enable, active-high.
- nLb  output  1  B load, active-low.
- nLo  output  1  output register load, active-low.
- HLT  output  1  halt flag, active-high, sticky.

Behaviour:
- Sequential state:
  - tstate register: one-hot, NUM_T bits.
  - halted flag.
- Control outputs are combinational decode of (tstate, opcode, halted).
- Reset (CLR=1 at rising edge):
  - tstate=000001 (T1), halted=0, regardless of current state. This includes CLR asserted mid-instruction.
  - Resulting outputs: Ep=1, nLm=0, all other signals inactive (Cp=0, nCE=1, nLi=1, nEi=1, nLa=1, Ea=0, Su=0, Eu=0, nLb=1, nLo=1, HLT=0).
- Advance rule when not halted:
  - tstate rotates left each rising edge, T6 -> T1.
  - One instruction takes exactly 6 clocks.
- Default output value: every control signal is inactive unless listed below.
- Fetch, all opcodes:
  - T1: Ep=1, nLm=0.
  - T2: Cp=1.
  - T3: nCE=0, nLi=0.
- Execute by opcode:
  - 0000 LDA:
    - T4: nEi=0, nLm=0.
    - T5: nCE=0, nLa=0.
    - T6: idle.
  - 0001 ADD:
    - T4: nEi=0, nLm=0.
    - T5: nCE=0, nLb=0.
    - T6: Eu=1, nLa=0.
  - 0010 SUB: same as ADD, except T6 is Su=1, Eu=1, nLa=0.
  - 1110 OUT:
    - T4: Ea=1, nLo=0.
    - T5, T6: idle.
  - 1111 HLT:
    - In T4, HLT=1 combinationally.
    - On that rising edge halted<=1 and tstate holds at T4.
    - While halted: tstate frozen, HLT=1, all other controls inactive.
    - Only CLR exits the halted state.
  - Any other opcode: NOP. T4–T6 idle; sequencing continues.
- Bus-drive rule: at most one bus driver (Ep, nCE=0, nEi=0, Ea, Eu) is active in any T-state. The verifier checks this with an assertion every cycle.
- Su is asserted only together with Eu.
- Illegal tstate (not one-hot) is unreachable. If detected, the next edge forces T1.

Decomposition:
- Shared package sap1_pkg holds:
  - opcode constants OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT.
  - one-hot T-state constants T1..T6.
  - control-word bit indices.
  - the inactive control-word constant CON_IDLE.
- One natural sub-module: sap1_ring_counter.
  - NUM_T-bit one-hot rotator with synchronous CLR to T1, a hold input (driven by halted), and illegal-state recovery.
- Decode stays in the parent module.

Test Plan:
- Reset: CLR=1 for 2 clocks -> tstate=000001, Ep=1, nLm=0, HLT=0, all other controls inactive; after release, tstate sequence is 000010, 000100, … 100000, 000001.
- LDA: opcode=0000 -> T4 nEi=0 & nLm=0; T5 nCE=0 & nLa=0; T6 all inactive; next edge returns to T1.
- ADD then SUB: opcode=0001 -> T5 nLb=0, T6 Eu=1 & nLa=0 & Su=0; next cycle opcode=0010 -> T6 Su=1, Eu=1, nLa=0.
- OUT and NOP: opcode=1110 -> T4 Ea=1 & nLo=0; opcode=0101 -> T4–T6 all controls inactive; sequencer continues to T1.
- HLT: opcode=1111 -> HLT=1 in T4; tstate stays 001000 for 10+ clocks with HLT=1 and all others inactive; CLR=1 -> T1, HLT=0.
- Mid-instruction reset: CLR=1 at T5 of ADD -> next edge tstate=000001, Ep=1, nLm=0, nLb=1; a bus-conflict assertion runs throughout all scenarios.

Source files
------------

// File: rtl/sap1_pkg.sv
// Shared definitions for the SAP-1 control sequencer.
// Holds the instruction-format widths, the opcode encodings, the one-hot
// T-state constants, the bit positions of every signal in the 12-bit
// control word and the all-inactive control word CON_IDLE.
package sap1_pkg;

   localparam int OPCODE_W = 4;
   localparam int NUM_T    = 6;
   localparam int CW_W     = 12;

   typedef enum logic [OPCODE_W-1:0] {
      OP_LDA = 4'b0000,
      OP_ADD = 4'b0001,
      OP_SUB = 4'b0010,
      OP_OUT = 4'b1110,
      OP_HLT = 4'b1111
   } opcode_e;

   localparam logic [NUM_T-1:0] T1 = 6'b000001;
   localparam logic [NUM_T-1:0] T2 = 6'b000010;
   localparam logic [NUM_T-1:0] T3 = 6'b000100;
   localparam logic [NUM_T-1:0] T4 = 6'b001000;
   localparam logic [NUM_T-1:0] T5 = 6'b010000;
   localparam logic [NUM_T-1:0] T6 = 6'b100000;

   // Control word layout, MSB first: Cp Ep nLm nCE nLi nEi nLa Ea Su Eu nLb nLo
   localparam int CW_CP  = 11;
   localparam int CW_EP  = 10;
   localparam int CW_NLM = 9;
   localparam int CW_NCE = 8;
   localparam int CW_NLI = 7;
   localparam int CW_NEI = 6;
   localparam int CW_NLA = 5;
   localparam int CW_EA  = 4;
   localparam int CW_SU  = 3;
   localparam int CW_EU  = 2;
   localparam int CW_NLB = 1;
   localparam int CW_NLO = 0;

   typedef logic [CW_W-1:0] ctrl_word_t;

   // Active-low strobes sit at 1, active-high enables at 0.
   localparam ctrl_word_t CON_IDLE = 12'b0011_1110_0011;

endpackage

// File: rtl/sap1_control_sequencer_if.sv
// Bus between the SAP-1 control sequencer and the datapath.
// Carries the opcode from the IR into the sequencer and the T-state,
// the 12 control strobes and the HLT flag back out to the datapath.
//   master : the sequencer (reads opcode, drives everything else)
//   slave  : the datapath side (drives opcode, reads controls)
interface sap1_control_sequencer_if;
   import sap1_pkg::*;

   logic [OPCODE_W-1:0] opcode;
   logic [NUM_T-1:0]    tstate;
   logic                Cp;
   logic                Ep;
   logic                nLm;
   logic                nCE;
   logic                nLi;
   logic                nEi;
   logic                nLa;
   logic                Ea;
   logic                Su;
   logic                Eu;
   logic                nLb;
   logic                nLo;
   logic                HLT;

   modport master (
      input  opcode,
      output tstate, Cp, Ep, nLm, nCE, nLi, nEi, nLa, Ea, Su, Eu, nLb, nLo, HLT
   );

   modport slave (
      output opcode,
      input  tstate, Cp, Ep, nLm, nCE, nLi, nEi, nLa, Ea, Su, Eu, nLb, nLo, HLT
   );

endinterface

// File: rtl/sap1_ring_counter.sv
// One-hot T-state ring counter for the SAP-1 sequencer.
// Ports:
//   CLK    rising-edge clock
//   CLR    synchronous active-high clear, forces T1
//   hold   freezes the current state (used while halted)
//   tstate one-hot state, bit0 = T1
module sap1_ring_counter #(
   parameter int NUM_T = 6
) (
   input  logic             CLK,
   input  logic             CLR,
   input  logic             hold,
   output logic [NUM_T-1:0] tstate
);

   localparam logic [NUM_T-1:0] FIRST = {{(NUM_T-1){1'b0}}, 1'b1};

   logic legal;

   // A value is one-hot when it is non-zero and clearing its lowest set
   // bit leaves nothing behind.
   assign legal = (tstate != '0) && ((tstate & (tstate - FIRST)) == '0);

   // Clear and corrupted states both land on T1; corruption recovery
   // takes priority over hold so a frozen counter cannot stay illegal.
   always_ff @(posedge CLK) begin
      if (CLR) begin
         tstate <= FIRST;
      end else if (!legal) begin
         tstate <= FIRST;
      end else if (!hold) begin
         tstate <= {tstate[NUM_T-2:0], tstate[NUM_T-1]};
      end
   end

endmodule

// File: rtl/sap1_control_sequencer.sv
// SAP-1 control sequencer.
// Steps a six-state ring counter and decodes (T-state, opcode, halted)
// into the 12-bit control word and the sticky HLT flag.
// Ports:
//   CLK  rising-edge clock
//   CLR  synchronous active-high reset (back to T1, not halted)
//   bus  master side of sap1_control_sequencer_if: opcode in,
//        tstate / Cp Ep nLm nCE nLi nEi nLa Ea Su Eu nLb nLo / HLT out
module sap1_control_sequencer
   import sap1_pkg::*;
(
   input logic                      CLK,
   input logic                      CLR,
   sap1_control_sequencer_if.master bus
);

   logic [NUM_T-1:0] tstate;
   logic             halted;
   logic             hlt;
   ctrl_word_t       cw;

   // hlt doubles as the counter hold: it is already high during the T4
   // of a HLT instruction, so the counter freezes on that very edge.
   sap1_ring_counter #(
      .NUM_T(NUM_T)
   ) u_ring (
      .CLK   (CLK),
      .CLR   (CLR),
      .hold  (hlt),
      .tstate(tstate)
   );

   // Sticky halt: once set, only CLR releases it.
   always_ff @(posedge CLK) begin
      if (CLR) begin
         halted <= 1'b0;
      end else if (hlt) begin
         halted <= 1'b1;
      end
   end

   // Control decode. Fetch (T1-T3) is opcode independent; execute
   // (T4-T6) depends on the opcode. Unknown opcodes and unreachable
   // T-state values fall through to the idle word.
   always_comb begin
      cw  = CON_IDLE;
      hlt = halted;
      if (!halted) begin
         case (tstate)
            T1: begin
               cw[CW_EP]  = 1'b1;
               cw[CW_NLM] = 1'b0;
            end
            T2: begin
               cw[CW_CP] = 1'b1;
            end
            T3: begin
               cw[CW_NCE] = 1'b0;
               cw[CW_NLI] = 1'b0;
            end
            T4: begin
               case (bus.opcode)
                  OP_LDA, OP_ADD, OP_SUB: begin
                     cw[CW_NEI] = 1'b0;
                     cw[CW_NLM] = 1'b0;
                  end
                  OP_OUT: begin
                     cw[CW_EA]  = 1'b1;
                     cw[CW_NLO] = 1'b0;
                  end
                  OP_HLT: begin
                     hlt = 1'b1;
                  end
                  default: begin
                  end
               endcase
            end
            T5: begin
               case (bus.opcode)
                  OP_LDA: begin
                     cw[CW_NCE] = 1'b0;
                     cw[CW_NLA] = 1'b0;
                  end
                  OP_ADD, OP_SUB: begin
                     cw[CW_NCE] = 1'b0;
                     cw[CW_NLB] = 1'b0;
                  end
                  default: begin
                  end
               endcase
            end
            T6: begin
               case (bus.opcode)
                  OP_ADD: begin
                     cw[CW_EU]  = 1'b1;
                     cw[CW_NLA] = 1'b0;
                  end
                  OP_SUB: begin
                     cw[CW_SU]  = 1'b1;
                     cw[CW_EU]  = 1'b1;
                     cw[CW_NLA] = 1'b0;
                  end
                  default: begin
                  end
               endcase
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.tstate = tstate;
   assign bus.Cp     = cw[CW_CP];
   assign bus.Ep     = cw[CW_EP];
   assign bus.nLm    = cw[CW_NLM];
   assign bus.nCE    = cw[CW_NCE];
   assign bus.nLi    = cw[CW_NLI];
   assign bus.nEi    = cw[CW_NEI];
   assign bus.nLa    = cw[CW_NLA];
   assign bus.Ea     = cw[CW_EA];
   assign bus.Su     = cw[CW_SU];
   assign bus.Eu     = cw[CW_EU];
   assign bus.nLb    = cw[CW_NLB];
   assign bus.nLo    = cw[CW_NLO];
   assign bus.HLT    = hlt;

endmodule

// File: tb/tb_sap1_control_sequencer.sv
// Self-checking bench for sap1_control_sequencer.
// Each directed step drives CLR/opcode, pushes the state expected after
// the next rising edge onto a scoreboard, then pops and compares on the
// following falling edge. A monitor checks bus exclusivity every cycle.
module tb_sap1_control_sequencer;

   typedef struct {
      logic [5:0]  t;
      logic [11:0] cw;
      logic        h;
      string       tag;
   } exp_t;

   // Expected T-states
   localparam logic [5:0] S1 = 6'b000001;
   localparam logic [5:0] S2 = 6'b000010;
   localparam logic [5:0] S3 = 6'b000100;
   localparam logic [5:0] S4 = 6'b001000;
   localparam logic [5:0] S5 = 6'b010000;
   localparam logic [5:0] S6 = 6'b100000;

   // Expected control words, order Cp Ep nLm nCE nLi nEi nLa Ea Su Eu nLb nLo
   localparam logic [11:0] W_IDLE = 12'b0011_1110_0011;
   localparam logic [11:0] W_F1   = 12'b0101_1110_0011;
   localparam logic [11:0] W_F2   = 12'b1011_1110_0011;
   localparam logic [11:0] W_F3   = 12'b0010_0110_0011;
   localparam logic [11:0] W_ADR  = 12'b0001_1010_0011;
   localparam logic [11:0] W_LDA5 = 12'b0010_1100_0011;
   localparam logic [11:0] W_ADD5 = 12'b0010_1110_0001;
   localparam logic [11:0] W_ADD6 = 12'b0011_1100_0111;
   localparam logic [11:0] W_SUB6 = 12'b0011_1100_1111;
   localparam logic [11:0] W_OUT4 = 12'b0011_1111_0010;

   logic CLK;
   logic CLR;
   logic armed;
   int   total;
   int   bad;
   exp_t sb[$];

   sap1_control_sequencer_if bus();

   sap1_control_sequencer dut (
      .CLK(CLK),
      .CLR(CLR),
      .bus(bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic checkOutput();
      exp_t        e;
      logic [18:0] obs;
      logic [18:0] want;
      obs = {bus.tstate, bus.Cp, bus.Ep, bus.nLm, bus.nCE, bus.nLi, bus.nEi,
             bus.nLa, bus.Ea, bus.Su, bus.Eu, bus.nLb, bus.nLo, bus.HLT};
      total++;
      if (sb.size() == 0) begin
         bad++;
         $error("[TB] FAIL scoreboard: no expectation queued, observed %b", obs);
         return;
      end
      e    = sb.pop_front();
      want = {e.t, e.cw, e.h};
      assert (obs === want) else begin
         bad++;
         $error("[TB] FAIL %s: got t=%b cw=%b hlt=%b, want t=%b cw=%b hlt=%b",
                e.tag, obs[18:13], obs[12:1], obs[0], e.t, e.cw, e.h);
      end
   endtask

   task automatic applyStimulus(input logic clr, input logic [3:0] op,
                                input logic [5:0] et, input logic [11:0] ecw,
                                input logic eh, input string tag);
      exp_t e;
      CLR        = clr;
      bus.opcode = op;
      e.t   = et;
      e.cw  = ecw;
      e.h   = eh;
      e.tag = tag;
      sb.push_back(e);
      @(posedge CLK);
      @(negedge CLK);
      checkOutput();
   endtask

   // At most one bus driver per cycle, and Su never without Eu.
   always @(negedge CLK) begin
      if (armed) begin
         int drivers;
         drivers = int'(bus.Ep) + int'(!bus.nCE) + int'(!bus.nEi) + int'(bus.Ea) + int'(bus.Eu);
         total++;
         assert (drivers <= 1) else begin
            bad++;
            $error("[TB] FAIL bus_conflict: got %0d drivers, want at most 1 (t=%b)", drivers, bus.tstate);
         end
         total++;
         assert (!bus.Su || bus.Eu) else begin
            bad++;
            $error("[TB] FAIL su_without_eu: got Su=%b Eu=%b, want Su only with Eu", bus.Su, bus.Eu);
         end
      end
   end

   initial begin
      total      = 0;
      bad        = 0;
      armed      = 1'b0;
      CLR        = 1'b1;
      bus.opcode = 4'b0000;
      @(negedge CLK);

      // Reset held for two clocks
      applyStimulus(1'b1, 4'b0000, S1, W_F1, 1'b0, "reset_1");
      armed = 1'b1;
      applyStimulus(1'b1, 4'b0000, S1, W_F1, 1'b0, "reset_2");

      // LDA
      applyStimulus(1'b0, 4'b0000, S2, W_F2,   1'b0, "lda_t2");
      applyStimulus(1'b0, 4'b0000, S3, W_F3,   1'b0, "lda_t3");
      applyStimulus(1'b0, 4'b0000, S4, W_ADR,  1'b0, "lda_t4");
      applyStimulus(1'b0, 4'b0000, S5, W_LDA5, 1'b0, "lda_t5");
      applyStimulus(1'b0, 4'b0000, S6, W_IDLE, 1'b0, "lda_t6");
      applyStimulus(1'b0, 4'b0000, S1, W_F1,   1'b0, "lda_wrap");

      // ADD
      applyStimulus(1'b0, 4'b0001, S2, W_F2,   1'b0, "add_t2");
      applyStimulus(1'b0, 4'b0001, S3, W_F3,   1'b0, "add_t3");
      applyStimulus(1'b0, 4'b0001, S4, W_ADR,  1'b0, "add_t4");
      applyStimulus(1'b0, 4'b0001, S5, W_ADD5, 1'b0, "add_t5");
      applyStimulus(1'b0, 4'b0001, S6, W_ADD6, 1'b0, "add_t6");
      applyStimulus(1'b0, 4'b0001, S1, W_F1,   1'b0, "add_wrap");

      // SUB
      applyStimulus(1'b0, 4'b0010, S2, W_F2,   1'b0, "sub_t2");
      applyStimulus(1'b0, 4'b0010, S3, W_F3,   1'b0, "sub_t3");
      applyStimulus(1'b0, 4'b0010, S4, W_ADR,  1'b0, "sub_t4");
      applyStimulus(1'b0, 4'b0010, S5, W_ADD5, 1'b0, "sub_t5");
      applyStimulus(1'b0, 4'b0010, S6, W_SUB6, 1'b0, "sub_t6");
      applyStimulus(1'b0, 4'b0010, S1, W_F1,   1'b0, "sub_wrap");

      // OUT
      applyStimulus(1'b0, 4'b1110, S2, W_F2,   1'b0, "out_t2");
      applyStimulus(1'b0, 4'b1110, S3, W_F3,   1'b0, "out_t3");
      applyStimulus(1'b0, 4'b1110, S4, W_OUT4, 1'b0, "out_t4");
      applyStimulus(1'b0, 4'b1110, S5, W_IDLE, 1'b0, "out_t5");
      applyStimulus(1'b0, 4'b1110, S6, W_IDLE, 1'b0, "out_t6");
      applyStimulus(1'b0, 4'b1110, S1, W_F1,   1'b0, "out_wrap");

      // NOP (unassigned opcode)
      applyStimulus(1'b0, 4'b0101, S2, W_F2,   1'b0, "nop_t2");
      applyStimulus(1'b0, 4'b0101, S3, W_F3,   1'b0, "nop_t3");
      applyStimulus(1'b0, 4'b0101, S4, W_IDLE, 1'b0, "nop_t4");
      applyStimulus(1'b0, 4'b0101, S5, W_IDLE, 1'b0, "nop_t5");
      applyStimulus(1'b0, 4'b0101, S6, W_IDLE, 1'b0, "nop_t6");
      applyStimulus(1'b0, 4'b0101, S1, W_F1,   1'b0, "nop_wrap");

      // HLT: freezes at T4 until CLR
      applyStimulus(1'b0, 4'b1111, S2, W_F2,   1'b0, "hlt_t2");
      applyStimulus(1'b0, 4'b1111, S3, W_F3,   1'b0, "hlt_t3");
      applyStimulus(1'b0, 4'b1111, S4, W_IDLE, 1'b1, "hlt_t4");
      for (int i = 0; i < 12; i++) begin
         applyStimulus(1'b0, 4'b1111, S4, W_IDLE, 1'b1, "hlt_frozen");
      end
      // Opcode change while halted must not wake it up
      applyStimulus(1'b0, 4'b0001, S4, W_IDLE, 1'b1, "hlt_other_op");
      applyStimulus(1'b1, 4'b0001, S1, W_F1,   1'b0, "hlt_clear");

      // Mid-instruction reset during T5 of ADD
      applyStimulus(1'b0, 4'b0001, S2, W_F2,   1'b0, "mid_t2");
      applyStimulus(1'b0, 4'b0001, S3, W_F3,   1'b0, "mid_t3");
      applyStimulus(1'b0, 4'b0001, S4, W_ADR,  1'b0, "mid_t4");
      applyStimulus(1'b0, 4'b0001, S5, W_ADD5, 1'b0, "mid_t5");
      applyStimulus(1'b1, 4'b0001, S1, W_F1,   1'b0, "mid_reset");
      applyStimulus(1'b0, 4'b0001, S2, W_F2,   1'b0, "mid_resume");

      armed = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
